// File: rtl/interval_timer.sv
// interval_timer: counts enabled ticks up to a runtime-loadable terminal count.
// Supports one-shot and periodic modes, hold (pause), synchronous clear and
// registered fin/wrap/busy outputs.
// Optional feature macro: TIMER_PRESCALE_EN adds an i_presc_div port and a tick
// prescaler; when undefined every un-held cycle in RUN is a tick.
module interval_timer #(
    parameter int unsigned WIDTH         = 9,
    parameter int unsigned DEFAULT_LIMIT = 350,
    parameter int unsigned PRESC_WIDTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_en,
    input  logic                   i_hold,
    input  logic                   i_clr,
    input  logic                   i_mode,
    input  logic                   i_limit_wr,
    input  logic [WIDTH-1:0]       i_limit_in,
`ifdef TIMER_PRESCALE_EN
    input  logic [PRESC_WIDTH-1:0] i_presc_div,
`endif
    output logic [WIDTH-1:0]       o_count,
    output logic                   o_fin,
    output logic                   o_wrap,
    output logic                   o_busy
);

    localparam logic [WIDTH-1:0] LP_DEFAULT_LIMIT = WIDTH'(DEFAULT_LIMIT);
    localparam logic [WIDTH-1:0] LP_ONE           = WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_count_inc;
    logic [WIDTH-1:0] r_limit;
    logic             r_fin;
    logic             r_wrap;
    logic             r_busy;
    logic             w_wrap_next;
    logic             w_active;
    logic             w_tick;

    // A counting opportunity: enabled, not cleared, not paused, and in RUN.
    assign w_active    = i_en && !i_clr && !i_hold && (r_state == StRun);
    assign w_count_inc = r_count + LP_ONE;

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [PRESC_WIDTH-1:0] w_presc_next;

    // Tick fires when the prescaler has reached the programmed divisor.
    assign w_tick = (r_presc == i_presc_div);

    // Prescaler next state: cleared by disable/clear, advanced only while active.
    always_comb begin
        w_presc_next = r_presc;
        if (!i_en || i_clr) begin
            w_presc_next = '0;
        end else if (w_active) begin
            if (w_tick) begin
                w_presc_next = '0;
            end else begin
                w_presc_next = r_presc + PRESC_WIDTH'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_presc_next;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // Next-state, next-count and wrap pulse, in priority order en > clr > hold > tick.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (!i_en) begin
            w_state_next = StIdle;
            w_count_next = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    // Entering RUN does not take a count on this edge.
                    w_state_next = StRun;
                    w_count_next = '0;
                end
                StRun, StDone: begin
                    if (i_clr) begin
                        w_state_next = StRun;
                        w_count_next = '0;
                    end else if (w_active && w_tick) begin
                        if (!i_mode) begin
                            // >= also catches a limit lowered below the current count.
                            if (r_count >= r_limit) begin
                                w_state_next = StDone;
                            end else begin
                                w_count_next = w_count_inc;
                                if (w_count_inc == r_limit) begin
                                    w_state_next = StDone;
                                end
                            end
                        end else begin
                            if (r_count >= r_limit) begin
                                w_count_next = '0;
                                w_wrap_next  = 1'b1;
                            end else begin
                                w_count_next = w_count_inc;
                            end
                        end
                    end
                end
                default: begin
                    w_state_next = StIdle;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // State, count and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_count <= '0;
            r_fin   <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_fin   <= (w_state_next == StDone);
            r_wrap  <= w_wrap_next;
            r_busy  <= (w_state_next == StRun);
        end
    end

    // Limit register; a tick on the load edge still sees the old value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_limit <= LP_DEFAULT_LIMIT;
        end else if (i_limit_wr) begin
            r_limit <= i_limit_in;
        end
    end

    assign o_count = r_count;
    assign o_fin   = r_fin;
    assign o_wrap  = r_wrap;
    assign o_busy  = r_busy;

endmodule
